rca_seq_adder: RTL and testbench



---
 rtl/rca_seq_adder_pkg.sv | 20 ++
 rtl/rca_seq_adder_slice.sv | 29 ++
 rtl/rca_seq_adder.sv | 132 +++++++++++++
 tb/tb_rca_seq_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_pkg - FSM state encoding and chunk-count helper for rca_seq_adder, rev 1.0
// ---------------------------------------------------------------------------
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns 0 for an illegal WIDTH/CHUNK pair so the top can refuse to elaborate.
  function automatic int calc_nchunk(input int width, input int chunk);
    if (width < 1 || chunk < 1 || (width % chunk) != 0) return 0;
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_seq_adder_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_slice - combinational CHUNK-bit ripple-carry slice, rev 1.0
// ---------------------------------------------------------------------------
module rca_slice
  import rca_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    assign s[g]     = x[g] ^ y[g] ^ w_c[g];
    assign w_c[g+1] = (x[g] & y[g]) | (x[g] & w_c[g]) | (y[g] & w_c[g]);
  end

  assign co = w_c[CHUNK];

endmodule
`default_nettype wire

// File: rtl/rca_seq_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_seq_adder - multi-cycle ripple-carry adder, one CHUNK slice per cycle;
// define RCA_SEQ_SUB_EN to add the sub (a - b) input. rev 1.0
// ---------------------------------------------------------------------------
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (NCHUNK == 0) begin : g_bad_param
    $error("rca_seq_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CHUNK-1:0] w_x, w_y, w_s;
  logic             w_co;

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        w_x = a_q[k*CHUNK +: CHUNK];
        w_y = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  rca_slice #(.CHUNK(CHUNK)) u_slice (
    .x  (w_x),
    .y  (w_y),
    .ci (carry_q),
    .s  (w_s),
    .co (w_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
`ifdef RCA_SEQ_SUB_EN
          // Subtract as a + ~b + 1; cin is ignored in that mode.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) sum_d[k*CHUNK +: CHUNK] = w_s;
        end
        carry_d = w_co;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = w_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rca_seq_adder - directed and random checks against an arithmetic model, rev 1.0
// ---------------------------------------------------------------------------
module tb_rca_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_n, out_ready;
  logic        in_valid, in_ready, cin, out_valid, cout, busy;
  logic [15:0] a, b, sum;
`ifdef RCA_SEQ_SUB_EN
  logic        sub;
`endif
  logic        s_in_valid, s_in_ready, s_cin, s_out_valid, s_cout, s_busy;
  logic [3:0]  s_a, s_b, s_sum;
  logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_cout, w_busy;
  logic [15:0] w_a, w_b, w_sum;

  rca_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  rca_seq_adder #(.WIDTH(4), .CHUNK(1)) dut_ser (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin),
`ifdef RCA_SEQ_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .cout(s_cout), .busy(s_busy)
  );

  rca_seq_adder #(.WIDTH(16), .CHUNK(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin),
`ifdef RCA_SEQ_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(w_out_valid), .out_ready(out_ready), .sum(w_sum), .cout(w_cout), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} is the true (WIDTH+1)-bit result.
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + 17'd1;
    return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  // One transaction on the 16/4 DUT; hold = extra DONE cycles with out_ready low.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                       input logic xs, input int hold);
    logic [16:0] e;
    e = ref16(xa, xb, xc, xs);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    cin       = xc;
`ifdef RCA_SEQ_SUB_EN
    sub       = xs;
`endif
    out_ready = (hold == 0);
    @(negedge clk);
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
    sub      = 1'($urandom);
`endif
    in_valid = (hold > 0);
    for (int c = 1; c <= 4; c++) begin
      chk("run_out_valid", out_valid, 0);
      chk("run_busy", busy, 1);
      chk("run_in_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("done_out_valid", out_valid, 1);
    chk("done_busy", busy, 1);
    chk("done_in_ready", in_ready, 0);
    chk("sum", sum, e[15:0]);
    chk("cout", cout, e[16]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", sum, e[15:0]);
      chk("hold_cout", cout, e[16]);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("after_out_valid", out_valid, 0);
    chk("after_busy", busy, 0);
    chk("after_in_ready", in_ready, 1);
  endtask

  task automatic ser_vec(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] e;
    e = {1'b0, xa} + {1'b0, xb} + {4'd0, xc};
    @(negedge clk);
    s_in_valid = 1'b1;
    s_a = xa;
    s_b = xb;
    s_cin = xc;
    @(negedge clk);
    s_in_valid = 1'b0;
    s_a = ~xa;
    s_b = ~xb;
    repeat (3) @(negedge clk);
    chk("ser_early_valid", s_out_valid, 0);
    @(negedge clk);
    chk("ser_result", {s_out_valid, s_cout, s_sum}, {1'b1, e});
  endtask

  task automatic wide_vec(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    logic [16:0] e;
    e = ref16(xa, xb, xc, 1'b0);
    @(negedge clk);
    w_in_valid = 1'b1;
    w_a = xa;
    w_b = xb;
    w_cin = xc;
    @(negedge clk);
    w_in_valid = 1'b0;
    w_a = 16'($urandom);
    w_b = 16'($urandom);
    chk("wide_early_valid", w_out_valid, 0);
    @(negedge clk);
    chk("wide_result", {w_out_valid, w_cout, w_sum}, {1'b1, e});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;
    int          rh;
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 3);

    // Reset during the second RUN cycle abandons the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_result", out_valid, 0);
    end

`ifdef RCA_SEQ_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      rh = int'($urandom_range(0, 2));
      do_op(ra, rb, rc, rs, rh);
    end

    for (int i = 0; i < 512; i++) begin
      ser_vec(i[3:0], i[7:4], i[8]);
    end

    for (int i = 0; i < 200; i++) begin
      wide_vec(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
